display_scheduler: RTL and testbench

Time-shares the single 4-digit seven-segment driver among three display sources in the parking controller:
- source 0: free-space count
- source 1: time of day, shown with the colon
- source 2: gate/fault alert

Sources 0 and 1 rotate round-robin, each shown for a minimum dwell. Source 2 pre-empts both. The block drives the driver's `digit_0..digit_3` and `enable_colon` inputs from registered outputs and returns one-hot grant/ack to the requesters.

---
 rtl/display_scheduler.sv | 199 +++++++++++++++++++
 tb/tb_display_scheduler.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/display_scheduler.sv
// Arbitrates the 4-digit seven-segment driver among free-space, clock and alert sources.
// Optional build macro ALERT_BLINK_EN: ALERT blinks data2 against 4'hA digits on each tick.
module display_scheduler #(
  parameter int unsigned TICK_DIV   = 50000,
  parameter int unsigned HOLD_TICKS = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req0,
  input  logic        req1,
  input  logic        req2,
  input  logic [15:0] data0,
  input  logic [15:0] data1,
  input  logic [15:0] data2,
  input  logic        colon0,
  input  logic        colon1,
  input  logic        colon2,
  output logic [3:0]  digit_0,
  output logic [3:0]  digit_1,
  output logic [3:0]  digit_2,
  output logic [3:0]  digit_3,
  output logic        enable_colon,
  output logic [2:0]  grant,
  output logic [2:0]  ack,
  output logic        tick
);

  localparam int unsigned PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned HW = $clog2(HOLD_TICKS + 1);

  typedef enum logic [1:0] {IDLE, SHOW, ALERT} state_t;

  state_t        state_q, state_d;
  logic [PW-1:0] presc_q, presc_d;
  logic          tick_q, tick_d;
  logic [HW-1:0] hold_q, hold_d;
  logic          owner_q, owner_d;
  logic          rr_q, rr_d;
  logic [15:0]   cap_q, cap_d;
  logic          cap_colon_q, cap_colon_d;
  logic [2:0]    grant_q, grant_d;
  logic [2:0]    ack_q, ack_d;
  logic [15:0]   disp_q, disp_d;
  logic          colon_q, colon_d;
`ifdef ALERT_BLINK_EN
  logic          blink_q, blink_d;
`endif

  logic          dwell_met;
  logic          cur_req;
  logic          oth_req;
  logic          pref_req;
  logic [15:0]   alert_data;
  logic          alert_colon;

  // Free-running prescaler; tick is registered so it coincides with the terminal count.
  always_comb begin
    presc_d = (presc_q == PW'(TICK_DIV - 1)) ? '0 : presc_q + PW'(1);
    tick_d  = (presc_d == PW'(TICK_DIV - 1));
  end

  assign dwell_met = (hold_q == HW'(HOLD_TICKS));
  assign cur_req   = owner_q ? req1 : req0;
  assign oth_req   = owner_q ? req0 : req1;
  assign pref_req  = rr_q ? req1 : req0;

  // Next-state arbitration; req2 always wins, requester drop beats dwell expiry.
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    rr_d    = rr_q;
    case (state_q)
      IDLE: begin
        if (req2) begin
          state_d = ALERT;
        end else if (req0 || req1) begin
          state_d = SHOW;
          owner_d = pref_req ? rr_q : ~rr_q;
        end
      end
      SHOW: begin
        if (req2) begin
          state_d = ALERT;
          rr_d    = owner_q;
        end else if (!cur_req) begin
          state_d = IDLE;
        end else if (dwell_met && oth_req) begin
          owner_d = ~owner_q;
          rr_d    = owner_q;
        end
      end
      ALERT: begin
        if (!req2 && dwell_met) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Alert payload is captured while req2 is high and replayed during the residual dwell.
  always_comb begin
    cap_d       = req2 ? data2 : cap_q;
    cap_colon_d = req2 ? colon2 : cap_colon_q;
    alert_data  = req2 ? data2 : cap_q;
    alert_colon = req2 ? colon2 : cap_colon_q;
  end

`ifdef ALERT_BLINK_EN
  always_comb begin
    blink_d = blink_q;
    if (state_d == ALERT && state_q != ALERT) begin
      blink_d = 1'b0;
    end else if (tick_q) begin
      blink_d = ~blink_q;
    end
  end
`endif

  // Registered grant, ack, dwell counter and display image all follow the next state.
  always_comb begin
    grant_d = 3'b000;
    disp_d  = 16'hFFFF;
    colon_d = 1'b0;
    case (state_d)
      SHOW: begin
        grant_d = owner_d ? 3'b010 : 3'b001;
        disp_d  = owner_d ? data1 : data0;
        colon_d = owner_d ? colon1 : colon0;
      end
      ALERT: begin
        grant_d = 3'b100;
`ifdef ALERT_BLINK_EN
        disp_d  = blink_d ? 16'hAAAA : alert_data;
        colon_d = blink_d ? 1'b0 : alert_colon;
`else
        disp_d  = alert_data;
        colon_d = alert_colon;
`endif
      end
      default: begin
        grant_d = 3'b000;
      end
    endcase
    ack_d  = grant_d & ~grant_q;
    hold_d = hold_q;
    if (grant_d != grant_q) begin
      hold_d = '0;
    end else if (tick_q && !dwell_met) begin
      hold_d = hold_q + HW'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      presc_q     <= '0;
      tick_q      <= 1'b0;
      hold_q      <= '0;
      owner_q     <= 1'b0;
      rr_q        <= 1'b0;
      cap_q       <= 16'h0000;
      cap_colon_q <= 1'b0;
      grant_q     <= 3'b000;
      ack_q       <= 3'b000;
      disp_q      <= 16'hFFFF;
      colon_q     <= 1'b0;
`ifdef ALERT_BLINK_EN
      blink_q     <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      presc_q     <= presc_d;
      tick_q      <= tick_d;
      hold_q      <= hold_d;
      owner_q     <= owner_d;
      rr_q        <= rr_d;
      cap_q       <= cap_d;
      cap_colon_q <= cap_colon_d;
      grant_q     <= grant_d;
      ack_q       <= ack_d;
      disp_q      <= disp_d;
      colon_q     <= colon_d;
`ifdef ALERT_BLINK_EN
      blink_q     <= blink_d;
`endif
    end
  end

  assign digit_0      = disp_q[3:0];
  assign digit_1      = disp_q[7:4];
  assign digit_2      = disp_q[11:8];
  assign digit_3      = disp_q[15:12];
  assign enable_colon = colon_q;
  assign grant        = grant_q;
  assign ack          = ack_q;
  assign tick         = tick_q;

endmodule

// File: tb/tb_display_scheduler.sv
// Directed bench for display_scheduler with TICK_DIV=4, HOLD_TICKS=2; honours ALERT_BLINK_EN.
module tb_display_scheduler;

  logic        clk = 1'b0;
  logic        reset;
  logic        req0, req1, req2;
  logic [15:0] data0, data1, data2;
  logic        colon0, colon1, colon2;
  logic [3:0]  digit_0, digit_1, digit_2, digit_3;
  logic        enable_colon;
  logic [2:0]  grant, ack;
  logic        tick;
  logic [15:0] dig;

  int n_cmp = 0;
  int n_bad = 0;

  display_scheduler #(.TICK_DIV(4), .HOLD_TICKS(2)) dut (
    .clk(clk), .reset(reset),
    .req0(req0), .req1(req1), .req2(req2),
    .data0(data0), .data1(data1), .data2(data2),
    .colon0(colon0), .colon1(colon1), .colon2(colon2),
    .digit_0(digit_0), .digit_1(digit_1), .digit_2(digit_2), .digit_3(digit_3),
    .enable_colon(enable_colon), .grant(grant), .ack(ack), .tick(tick)
  );

  always #5 clk = ~clk;
  assign dig = {digit_3, digit_2, digit_1, digit_0};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Leaves the bench just after a clock edge with reset released; the next edge is edge 1.
  task automatic do_reset();
    reset = 1'b1;
    req0 = 1'b0; req1 = 1'b0; req2 = 1'b0;
    data0 = 16'h0; data1 = 16'h0; data2 = 16'h0;
    colon0 = 1'b0; colon1 = 1'b0; colon2 = 1'b0;
    step(2);
    reset = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] blink_dig;
    logic        blink_col;
`ifdef ALERT_BLINK_EN
    blink_dig = 16'hAAAA;
    blink_col = 1'b0;
`else
    blink_dig = 16'h1234;
    blink_col = 1'b1;
`endif

    // Reset values and single requester
    do_reset();
    check("rst_vals", {dig, enable_colon, grant, ack, tick}, {16'hFFFF, 1'b0, 3'b000, 3'b000, 1'b0});
    req0 = 1'b1; data0 = 16'h0123;
    step(1);
    check("single_grant", grant, 3'b001);
    check("single_ack", ack, 3'b001);
    check("single_dig", dig, 16'h0123);
    check("tick_e1", tick, 1'b0);
    step(1);
    check("single_ack_off", ack, 3'b000);
    check("single_hold_e2", grant, 3'b001);
    step(1);
    check("tick_e3", tick, 1'b1);
    step(1);
    check("tick_e4", tick, 1'b0);
    for (int i = 0; i < 40; i++) begin
      step(1);
      check("single_held", grant, 3'b001);
    end
    data0 = 16'h9876; colon0 = 1'b1;
    step(1);
    check("live_dig", dig, 16'h9876);
    check("live_colon", enable_colon, 1'b1);

    // Asynchronous reset in the middle of SHOW
    reset = 1'b1;
    #1;
    check("rst_mid", {dig, enable_colon, grant, ack, tick}, {16'hFFFF, 1'b0, 3'b000, 3'b000, 1'b0});

    // Rotation between sources 0 and 1
    do_reset();
    data0 = 16'h1111; data1 = 16'h2222; colon1 = 1'b1;
    req0 = 1'b1; req1 = 1'b1;
    step(1);
    check("rot_first", grant, 3'b001);
    check("rot_first_ack", ack, 3'b001);
    check("rot_first_col", enable_colon, 1'b0);
    step(7);
    check("rot_e8", grant, 3'b001);
    step(1);
    check("rot_sw1", grant, 3'b010);
    check("rot_sw1_ack", ack, 3'b010);
    check("rot_sw1_dig", dig, 16'h2222);
    check("rot_sw1_col", enable_colon, 1'b1);
    step(1);
    check("rot_sw1_ack_off", ack, 3'b000);
    step(6);
    check("rot_e16", grant, 3'b010);
    step(1);
    check("rot_sw0", grant, 3'b001);
    check("rot_sw0_ack", ack, 3'b001);
    check("rot_sw0_dig", dig, 16'h1111);
    check("rot_sw0_col", enable_colon, 1'b0);

    // Pre-emption of source 1 by a one-cycle alert
    do_reset();
    req1 = 1'b1; data1 = 16'h5678; colon1 = 1'b1;
    step(1);
    check("pre_show1", grant, 3'b010);
    check("pre_show1_dig", dig, 16'h5678);
    step(1);
    req2 = 1'b1; data2 = 16'h4444; colon2 = 1'b0;
    step(1);
    check("pre_grant", grant, 3'b100);
    check("pre_ack", ack, 3'b100);
    check("pre_dig", dig, 16'h4444);
    check("pre_col", enable_colon, 1'b0);
    req2 = 1'b0; data2 = 16'h9999; colon2 = 1'b1; req0 = 1'b1;
    step(1);
    check("pre_hold", grant, 3'b100);
`ifdef ALERT_BLINK_EN
    check("pre_cap_dig", dig, 16'hAAAA);
`else
    check("pre_cap_dig", dig, 16'h4444);
`endif
    check("pre_cap_col", enable_colon, 1'b0);
    step(4);
    check("pre_e8", grant, 3'b100);
    step(1);
    check("pre_idle", grant, 3'b000);
    check("pre_idle_dig", dig, 16'hFFFF);
    step(1);
    check("pre_resume", grant, 3'b010);
    check("pre_resume_ack", ack, 3'b010);

    // Requester drop coinciding with dwell met
    do_reset();
    req0 = 1'b1; req1 = 1'b1;
    step(1);
    check("drop_first", grant, 3'b001);
    step(7);
    check("drop_e8", grant, 3'b001);
    req0 = 1'b0;
    step(1);
    check("drop_idle", grant, 3'b000);
    check("drop_idle_dig", dig, 16'hFFFF);
    step(1);
    check("drop_next", grant, 3'b010);
    check("drop_next_ack", ack, 3'b010);

    // Held alert: steady, or blinking when ALERT_BLINK_EN is defined
    do_reset();
    req2 = 1'b1; data2 = 16'h1234; colon2 = 1'b1;
    step(1);
    check("alrt_grant", grant, 3'b100);
    check("alrt_ack", ack, 3'b100);
    check("alrt_dig_e1", dig, 16'h1234);
    check("alrt_col_e1", enable_colon, 1'b1);
    step(2);
    check("alrt_dig_e3", dig, 16'h1234);
    step(1);
    check("alrt_dig_e4", dig, blink_dig);
    check("alrt_col_e4", enable_colon, blink_col);
    step(3);
    check("alrt_dig_e7", dig, blink_dig);
    step(1);
    check("alrt_dig_e8", dig, 16'h1234);
    check("alrt_col_e8", enable_colon, 1'b1);
    req2 = 1'b0;
    step(1);
    check("alrt_exit", grant, 3'b000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
